// File: rtl/relu_maxpool.sv
// ReLU fused with non-overlapping P_SIZE x P_SIZE max pooling over a signed feature-map buffer.
// Reads each window element with a 3-phase read loop and writes one non-negative word per window.
module relu_maxpool #(
   parameter int unsigned D_BIT_WIDTH = 16,
   parameter int unsigned I_SIZE      = 4,
   parameter int unsigned CHANNELS    = 3,
   parameter int unsigned P_SIZE      = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          pool_en,
   input  logic                          pool_start,
   input  logic signed [D_BIT_WIDTH-1:0] src_buf_dout,
   output logic                          src_buf_cs,
   output logic                          src_buf_ren,
   output logic        [15:0]            src_buf_addr,
   output logic                          dst_buf_cs,
   output logic                          dst_buf_wen,
   output logic        [15:0]            dst_buf_addr,
   output logic        [D_BIT_WIDTH-1:0] dst_buf_din,
   output logic                          pool_busy,
   output logic                          pool_done
);

   localparam int unsigned O_SIZE = I_SIZE / P_SIZE;
   localparam int unsigned K_NUM  = P_SIZE * P_SIZE;
   localparam int unsigned CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned OW     = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
   localparam int unsigned KW     = (K_NUM > 1) ? $clog2(K_NUM) : 1;

   localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
   localparam logic [OW-1:0] O_LAST = OW'(O_SIZE - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K_NUM - 1);

   typedef enum logic [2:0] {StIdle, StRead, StWrite, StWrel, StDone} state_e;

   state_e                        state_q;
   logic        [CW-1:0]          ch_q;
   logic        [OW-1:0]          orow_q;
   logic        [OW-1:0]          ocol_q;
   logic        [KW-1:0]          k_q;
   logic        [1:0]             phase_q;
   logic signed [D_BIT_WIDTH-1:0] acc_q;
   logic        [15:0]            src_addr_d;
   logic        [15:0]            dst_addr_d;

   always_comb begin
      src_addr_d = 16'(32'(ch_q) * (I_SIZE * I_SIZE)
                     + (32'(orow_q) * P_SIZE + 32'(k_q) / P_SIZE) * I_SIZE
                     + 32'(ocol_q) * P_SIZE + 32'(k_q) % P_SIZE);
      dst_addr_d = 16'(32'(ch_q) * (O_SIZE * O_SIZE) + 32'(orow_q) * O_SIZE + 32'(ocol_q));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         ch_q         <= '0;
         orow_q       <= '0;
         ocol_q       <= '0;
         k_q          <= '0;
         phase_q      <= '0;
         acc_q        <= '0;
         src_buf_cs   <= 1'b0;
         src_buf_ren  <= 1'b1;
         src_buf_addr <= '0;
         dst_buf_cs   <= 1'b0;
         dst_buf_wen  <= 1'b1;
         dst_buf_addr <= '0;
         dst_buf_din  <= '0;
         pool_busy    <= 1'b0;
         pool_done    <= 1'b0;
      end else if (pool_en) begin
         case (state_q)
            StIdle, StDone: begin
               if (pool_start) begin
                  state_q   <= StRead;
                  ch_q      <= '0;
                  orow_q    <= '0;
                  ocol_q    <= '0;
                  k_q       <= '0;
                  phase_q   <= '0;
                  acc_q     <= '0;
                  pool_done <= 1'b0;
                  pool_busy <= 1'b1;
               end else if (state_q == StDone) begin
                  pool_done <= 1'b1;
                  pool_busy <= 1'b0;
               end
            end
            StRead: begin
               case (phase_q)
                  2'd0: begin
                     src_buf_cs   <= 1'b1;
                     src_buf_ren  <= 1'b0;
                     src_buf_addr <= src_addr_d;
                     phase_q      <= 2'd1;
                  end
                  2'd1: phase_q <= 2'd2;
                  default: begin
                     // acc starts at zero, so the signed max also implements ReLU
                     phase_q <= 2'd0;
                     if (src_buf_dout > acc_q) acc_q <= src_buf_dout;
                     if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= StWrite;
                     end else begin
                        k_q <= k_q + 1'b1;
                     end
                  end
               endcase
            end
            StWrite: begin
               dst_buf_cs   <= 1'b1;
               dst_buf_wen  <= 1'b0;
               dst_buf_addr <= dst_addr_d;
               dst_buf_din  <= acc_q;
               state_q      <= StWrel;
            end
            StWrel: begin
               dst_buf_cs  <= 1'b0;
               dst_buf_wen <= 1'b1;
               acc_q       <= '0;
               state_q     <= StRead;
               if (ocol_q != O_LAST) begin
                  ocol_q <= ocol_q + 1'b1;
               end else begin
                  ocol_q <= '0;
                  if (orow_q != O_LAST) begin
                     orow_q <= orow_q + 1'b1;
                  end else begin
                     orow_q <= '0;
                     if (ch_q != C_LAST) begin
                        ch_q <= ch_q + 1'b1;
                     end else begin
                        ch_q        <= '0;
                        src_buf_cs  <= 1'b0;
                        src_buf_ren <= 1'b1;
                        state_q     <= StDone;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
